// File: rtl/cache_types_pkg.sv
// Shared types and encodings for the N-way cache controller.
//   cache_state_e : controller FSM states
//   PMEM_ADDR_*   : pmem_mux_sel encodings (pmem address source)
//   DATA_SRC_*    : data_src_sel encodings (array write-data source)
package cache_types_pkg;

  typedef enum logic [1:0] {
    CHECK      = 2'd0,
    WRITE_BACK = 2'd1,
    ALLOCATE   = 2'd2
  } cache_state_e;

  localparam logic PMEM_ADDR_REQ    = 1'b0;
  localparam logic PMEM_ADDR_VICTIM = 1'b1;

  localparam logic DATA_SRC_CPU  = 1'b0;
  localparam logic DATA_SRC_PMEM = 1'b1;

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU state, NUM_WAYS-1 bits per set.
//   clk, reset   : clock, asynchronous active-high reset (clears all bits)
//   set_idx      : set being looked up / updated
//   victim_way   : combinational PLRU victim of set_idx
//   upd_en       : mark upd_way of set_idx as most recently used
//   upd_way      : way being accessed
// Nodes are heap-numbered from 1 (root). A node bit of 0 points the victim
// search at the lower-index half, 1 at the upper-index half.
module plru_tree
  import cache_types_pkg::*;
#(
  parameter int NUM_WAYS  = 4,
  parameter int NUM_SETS  = 8,
  parameter int WAY_IDX_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  parameter int SET_IDX_W = $clog2(NUM_SETS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SET_IDX_W-1:0] set_idx,
  output logic [WAY_IDX_W-1:0] victim_way,
  input  logic                 upd_en,
  input  logic [WAY_IDX_W-1:0] upd_way
);

  localparam int LEVELS = $clog2(NUM_WAYS);

  if (NUM_WAYS == 1) begin : g_single
    logic unused_inputs;
    assign unused_inputs = ^{clk, reset, set_idx, upd_en, upd_way};
    assign victim_way    = '0;
  end else begin : g_tree
    logic [NUM_WAYS-1:1] tree_q [NUM_SETS];
    logic [NUM_WAYS-1:1] cur_bits;
    logic [WAY_IDX_W-1:0] upd_node [LEVELS];
    logic                 upd_dir  [LEVELS];

    assign cur_bits = tree_q[set_idx];

    // Walk from the root; the chosen directions spell out the victim index.
    always_comb begin : victim_walk
      logic [WAY_IDX_W-1:0] node;
      logic [WAY_IDX_W-1:0] path;
      node = '0;
      path = '0;
      for (int l = 0; l < LEVELS; l++) begin
        node = WAY_IDX_W'(1 << l) | path;
        path = (path << 1) | WAY_IDX_W'(cur_bits[node]);
      end
      victim_way = path;
    end

    // Node on level l of the accessed way's path is 1 followed by the top
    // l bits of the way; the next way bit says which child was used.
    always_comb begin : upd_path
      logic [WAY_IDX_W-1:0] dir_bits;
      dir_bits = '0;
      for (int l = 0; l < LEVELS; l++) begin
        upd_node[l] = WAY_IDX_W'(1 << l) | WAY_IDX_W'(upd_way >> (LEVELS - l));
        dir_bits    = upd_way >> (LEVELS - 1 - l);
        upd_dir[l]  = dir_bits[0];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int s = 0; s < NUM_SETS; s++) tree_q[s] <= '0;
      end else if (upd_en) begin
        for (int l = 0; l < LEVELS; l++) tree_q[set_idx][upd_node[l]] <= ~upd_dir[l];
      end
    end
  end

endmodule

// File: rtl/cache_control_nway.sv
// Control FSM for an N-way set-associative write-back, write-allocate cache.
//   clk, reset            : clock, asynchronous active-high reset
//   mem_read/mem_write    : CPU request (held until mem_resp), set_idx stable
//   hit_vec/valid_vec/dirty_vec : per-way status of the indexed set
//   pmem_resp             : physical memory transaction done
//   mem_resp              : CPU request complete (only in CHECK)
//   pmem_read/pmem_write  : line fill / line write-back
//   pmem_mux_sel          : pmem address source (request tag / victim tag)
//   way_sel               : way driving data-out and receiving loads
//   load_data/load_tag/load_valid/set_dirty/clr_dirty : array strobes
//   data_src_sel          : array write source (CPU merge / pmem line)
// All outputs are combinational from state and inputs.
module cache_control_nway
  import cache_types_pkg::*;
#(
  parameter int NUM_WAYS  = 4,
  parameter int NUM_SETS  = 8,
  parameter int WAY_IDX_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  parameter int SET_IDX_W = $clog2(NUM_SETS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [SET_IDX_W-1:0] set_idx,
  input  logic [NUM_WAYS-1:0]  hit_vec,
  input  logic [NUM_WAYS-1:0]  valid_vec,
  input  logic [NUM_WAYS-1:0]  dirty_vec,
  input  logic                 pmem_resp,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic                 pmem_mux_sel,
  output logic [WAY_IDX_W-1:0] way_sel,
  output logic                 load_data,
  output logic                 load_tag,
  output logic                 load_valid,
  output logic                 set_dirty,
  output logic                 clr_dirty,
  output logic                 data_src_sel
);

  cache_state_e         state_q;
  logic [WAY_IDX_W-1:0] victim_q;

  logic                 mem_req;
  logic                 hit_any;
  logic [WAY_IDX_W-1:0] hit_way;
  logic                 inv_any;
  logic [WAY_IDX_W-1:0] inv_way;
  logic [WAY_IDX_W-1:0] plru_victim;
  logic [WAY_IDX_W-1:0] victim;
  logic                 victim_dirty;
  logic                 plru_upd_en;
  logic [WAY_IDX_W-1:0] plru_upd_way;

  assign mem_req = mem_read | mem_write;

  // Lowest-index priority encoders: scan downward so the lowest set bit wins.
  always_comb begin
    hit_any = |hit_vec;
    hit_way = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_way = WAY_IDX_W'(i);
    end
  end

  always_comb begin
    inv_any = ~&valid_vec;
    inv_way = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!valid_vec[i]) inv_way = WAY_IDX_W'(i);
    end
  end

  assign victim       = inv_any ? inv_way : plru_victim;
  assign victim_dirty = valid_vec[victim] & dirty_vec[victim];

  assign plru_upd_en  = ((state_q == CHECK) && mem_req && hit_any) ||
                        ((state_q == ALLOCATE) && pmem_resp);
  assign plru_upd_way = (state_q == ALLOCATE) ? victim_q : hit_way;

  plru_tree #(
    .NUM_WAYS (NUM_WAYS),
    .NUM_SETS (NUM_SETS),
    .WAY_IDX_W(WAY_IDX_W),
    .SET_IDX_W(SET_IDX_W)
  ) u_plru (
    .clk       (clk),
    .reset     (reset),
    .set_idx   (set_idx),
    .victim_way(plru_victim),
    .upd_en    (plru_upd_en),
    .upd_way   (plru_upd_way)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= CHECK;
      victim_q <= '0;
    end else begin
      case (state_q)
        CHECK: begin
          if (mem_req && !hit_any) begin
            victim_q <= victim;
            state_q  <= victim_dirty ? WRITE_BACK : ALLOCATE;
          end
        end
        // A dropped request is honoured only once the write-back finishes.
        WRITE_BACK: if (pmem_resp) state_q <= mem_req ? ALLOCATE : CHECK;
        ALLOCATE:   if (pmem_resp) state_q <= CHECK;
        default:    state_q <= CHECK;
      endcase
    end
  end

  always_comb begin
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_mux_sel = PMEM_ADDR_REQ;
    way_sel      = '0;
    load_data    = 1'b0;
    load_tag     = 1'b0;
    load_valid   = 1'b0;
    set_dirty    = 1'b0;
    clr_dirty    = 1'b0;
    data_src_sel = DATA_SRC_CPU;
    case (state_q)
      CHECK: begin
        if (mem_req && hit_any) begin
          mem_resp = 1'b1;
          way_sel  = hit_way;
          if (mem_write) begin
            load_data = 1'b1;
            set_dirty = 1'b1;
          end
        end
      end
      WRITE_BACK: begin
        pmem_write   = 1'b1;
        pmem_mux_sel = PMEM_ADDR_VICTIM;
        way_sel      = victim_q;
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        way_sel   = victim_q;
        if (pmem_resp) begin
          load_data    = 1'b1;
          load_tag     = 1'b1;
          load_valid   = 1'b1;
          clr_dirty    = 1'b1;
          data_src_sel = DATA_SRC_PMEM;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_control_nway.sv
module tb_cache_control_nway;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_read, mem_write;
  logic [2:0] set_idx;
  logic [3:0] hit_vec, valid_vec, dirty_vec;
  logic       pmem_resp;
  logic       mem_resp, pmem_read, pmem_write, pmem_mux_sel;
  logic [1:0] way_sel;
  logic       load_data, load_tag, load_valid, set_dirty, clr_dirty, data_src_sel;

  int checks = 0;
  int errors = 0;
  logic [12:0] exp_q[$];
  logic [12:0] obs;

  cache_control_nway #(.NUM_WAYS(4), .NUM_SETS(8)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .set_idx(set_idx), .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec),
    .pmem_resp(pmem_resp), .mem_resp(mem_resp), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_mux_sel(pmem_mux_sel), .way_sel(way_sel),
    .load_data(load_data), .load_tag(load_tag), .load_valid(load_valid),
    .set_dirty(set_dirty), .clr_dirty(clr_dirty), .data_src_sel(data_src_sel)
  );

  always #5 clk = ~clk;

  assign obs = {mem_resp, pmem_read, pmem_write, pmem_mux_sel, way_sel,
                load_data, load_tag, load_valid, set_dirty, clr_dirty, data_src_sel};

  function automatic logic [12:0] mk(input logic resp, prd, pwr, mux, input logic [1:0] way,
                                     input logic ld, lt, lv, sd, cd, ds);
    return {resp, prd, pwr, mux, way, ld, lt, lv, sd, cd, ds};
  endfunction

  function automatic logic [12:0] e_hit(input logic [1:0] w, input logic wr);
    return mk(1, 0, 0, 0, w, wr, 0, 0, wr, 0, 0);
  endfunction
  function automatic logic [12:0] e_wb(input logic [1:0] w);
    return mk(0, 0, 1, 1, w, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [12:0] e_al(input logic [1:0] w);
    return mk(0, 1, 0, 0, w, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [12:0] e_fill(input logic [1:0] w);
    return mk(0, 1, 0, 0, w, 1, 1, 1, 0, 1, 1);
  endfunction

  // Monitor: every cycle where the DUT drives anything non-zero is a response.
  always @(negedge clk) begin
    if (!reset) begin
      assert ($onehot0(hit_vec)) else $error("illegal multi-hit vector %b", hit_vec);
      if (obs != 13'd0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output t=%0t got %b expected idle", $time, obs);
        end else begin
          logic [12:0] e;
          e = exp_q.pop_front();
          if (obs !== e) begin
            errors++;
            $display("FAIL response t=%0t got %b expected %b", $time, obs, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read = 0; mem_write = 0; hit_vec = 4'b0000; pmem_resp = 0;
  endtask

  task automatic do_hit(input logic [2:0] s, input logic [1:0] w, input logic wr);
    set_idx = s; hit_vec = 4'b0001 << w; valid_vec = 4'b1111; dirty_vec = 4'b0000;
    mem_read = ~wr; mem_write = wr;
    exp_q.push_back(e_hit(w, wr));
    tick();
    idle_inputs();
  endtask

  // Full miss: miss cycle, optional write-back, fill, then the responding hit.
  task automatic do_miss(input logic [2:0] s, input logic [3:0] v, input logic [3:0] d,
                         input logic [1:0] vic, input logic wb, input int wbw,
                         input int alw, input logic rd, input logic wr);
    set_idx = s; valid_vec = v; dirty_vec = d; hit_vec = 4'b0000;
    mem_read = rd; mem_write = wr; pmem_resp = 0;
    tick();
    if (wb) begin
      for (int i = 0; i < wbw; i++) begin exp_q.push_back(e_wb(vic)); tick(); end
      pmem_resp = 1; exp_q.push_back(e_wb(vic)); tick(); pmem_resp = 0;
    end
    for (int i = 0; i < alw; i++) begin exp_q.push_back(e_al(vic)); tick(); end
    pmem_resp = 1; exp_q.push_back(e_fill(vic)); tick(); pmem_resp = 0;
    hit_vec = 4'b0001 << vic; valid_vec = v | (4'b0001 << vic);
    exp_q.push_back(e_hit(vic, wr));
    tick();
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; idle_inputs(); set_idx = 0; valid_vec = 0; dirty_vec = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    checks++;
    if (obs !== 13'd0) begin
      errors++; $display("FAIL reset_idle got %b expected 0", obs);
    end
    repeat (2) tick();

    // Read hit way 2 in set 0, then the set-0 victim must move off way 2 (to 0).
    do_hit(3'd0, 2'd2, 1'b0);
    do_miss(3'd0, 4'b1111, 4'b0000, 2'd0, 0, 0, 1, 1, 0);

    // Write hit way 0.
    do_hit(3'd0, 2'd0, 1'b1);

    // First invalid way is the victim, no write-back even with dirty bits set.
    do_miss(3'd1, 4'b1011, 4'b1111, 2'd2, 0, 0, 5, 1, 0);

    // Set 3: touch 0..3, miss full+dirty -> victim 0 via write-back; read+write acts as write.
    for (int w = 0; w < 4; w++) do_hit(3'd3, w[1:0], 1'b0);
    do_miss(3'd3, 4'b1111, 4'b1111, 2'd0, 1, 3, 2, 1, 1);
    // Tree now points at way 2.
    do_miss(3'd3, 4'b1111, 4'b0000, 2'd2, 0, 0, 0, 1, 0);

    // Request dropped during write-back: finish write-back, never allocate.
    set_idx = 3'd5; valid_vec = 4'b1111; dirty_vec = 4'b0001; mem_read = 1;
    tick();
    exp_q.push_back(e_wb(2'd0)); tick();
    mem_read = 0;
    exp_q.push_back(e_wb(2'd0)); tick();
    pmem_resp = 1; exp_q.push_back(e_wb(2'd0)); tick();
    pmem_resp = 0;
    repeat (3) tick();

    // Request dropped during allocate: fill still completes.
    set_idx = 3'd6; valid_vec = 4'b0111; dirty_vec = 4'b0000; mem_read = 1;
    tick();
    exp_q.push_back(e_al(2'd3)); tick();
    mem_read = 0;
    exp_q.push_back(e_al(2'd3)); tick();
    pmem_resp = 1; exp_q.push_back(e_fill(2'd3)); tick();
    pmem_resp = 0;
    repeat (2) tick();

    // Stray pmem_resp in CHECK is ignored.
    pmem_resp = 1; tick(); tick(); pmem_resp = 0; tick();

    // Reset in the middle of allocate: set 2 victim would be way 2 after hitting way 0.
    do_hit(3'd2, 2'd0, 1'b0);
    set_idx = 3'd2; valid_vec = 4'b1111; dirty_vec = 4'b0000; mem_read = 1;
    tick();
    exp_q.push_back(e_al(2'd2)); tick();
    checks++;
    if (pmem_read !== 1'b1) begin
      errors++; $display("FAIL alloc_before_reset pmem_read got %b expected 1", pmem_read);
    end
    #1 reset = 1;
    #1;
    checks++;
    if (obs !== 13'd0) begin
      errors++; $display("FAIL async_reset_drop got %b expected 0", obs);
    end
    mem_read = 0;
    repeat (2) @(posedge clk);
    #3 reset = 0;
    tick();
    // PLRU cleared: set 2 victim back to way 0.
    do_miss(3'd2, 4'b1111, 4'b0000, 2'd0, 0, 0, 0, 1, 0);

    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL missing_responses got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
